io_bridge_timer: RTL and testbench

- Downstream consumer of the EX-stage memory access path.
- Receives the IO-side write/address/data/byte-enable bundle for every access whose byte address is at or above 0x3000, and decodes it onto two memory-mapped countdown timers (one shared sub-module, instantiated twice).
- Returns registered read data with the same one-cycle latency as the data RAM.
- Drives hardware interrupt lines toward the CP0/exception logic.

---
 rtl/io_pkg.sv | 36 +++
 rtl/io_timer.sv | 113 +++++++++++
 rtl/io_bridge_timer.sv | 79 +++++++
 tb/tb_io_bridge_timer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the IO-space timer bridge: address map, CTRL fields, FSM encoding.
package io_pkg;

    localparam logic [15:0] T0_BASE_DEF = 16'h7F00;
    localparam logic [15:0] T1_BASE_DEF = 16'h7F10;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } timer_state_e;

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*8 +: 8] = be[i] ? wd[i*8 +: 8] : old_v[i*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/io_timer.sv
// One countdown timer with CTRL/PRESET/COUNT registers; rd is combinational from state,
// irq is the masked interrupt flag. No backpressure: writes are always accepted.
module io_timer
    import io_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  off,
    input  logic [31:0] wd,
    input  logic [3:0]  be,
    output logic [31:0] rd,
    output logic        irq
);

    timer_state_e state_q, state_d;
    logic [3:0]   ctrl_q, ctrl_d;
    logic [31:0]  preset_q, preset_d;
    logic [31:0]  count_q, count_d;
    logic         irq_q, irq_d;

    logic         wr_ctrl, wr_preset, mode_reload;
    logic [31:0]  ctrl_merged;

    assign wr_ctrl     = we && (off == OFF_CTRL);
    assign wr_preset   = we && (off == OFF_PRESET);
    assign mode_reload = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);
    assign ctrl_merged = be_merge({28'd0, ctrl_q}, wd, be);

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        irq_d    = irq_q;

        // Auto-reload flag is a single-cycle pulse.
        if (irq_q && mode_reload) begin
            irq_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (ctrl_q[CTRL_EN]) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[CTRL_EN]) begin
                    state_d = ST_IDLE;
                end else if (count_q == 32'd0) begin
                    state_d = ST_INT;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            ST_INT: begin
                irq_d   = 1'b1;
                state_d = ST_IDLE;
                if (!mode_reload) begin
                    ctrl_d[CTRL_EN] = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A configuration write overrides whatever the FSM was about to do.
        if (wr_ctrl || wr_preset) begin
            state_d = ST_IDLE;
            irq_d   = 1'b0;
            count_d = count_q;
            if (wr_ctrl) begin
                ctrl_d = ctrl_merged[3:0];
            end
            if (wr_preset) begin
                preset_d = be_merge(preset_q, wd, be);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= 4'd0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        rd = 32'd0;
        unique case (off)
            OFF_CTRL:   rd = {28'd0, ctrl_q};
            OFF_PRESET: rd = preset_q;
            OFF_COUNT:  rd = count_q;
            default:    rd = 32'd0;
        endcase
    end

    assign irq = irq_q & ctrl_q[CTRL_IM];

endmodule

// File: rtl/io_bridge_timer.sv
// IO-space bridge decoding two memory-mapped countdown timers and driving hw interrupt lines.
// Read data is registered (1-cycle latency, read-first); no backpressure.
module io_bridge_timer
    import io_pkg::*;
#(
    parameter logic [15:0] T0_BASE   = T0_BASE_DEF,
    parameter logic [15:0] T1_BASE   = T1_BASE_DEF,
    parameter int          NUM_HWINT = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_write,
    input  logic [29:0]          pr_addr,
    input  logic [31:0]          pr_wd,
    input  logic [3:0]           pr_be,
    output logic [31:0]          pr_rd,
    output logic [NUM_HWINT-1:0] hw_int
);

    logic        sel_t0, sel_t1;
    logic [1:0]  word_off;
    logic [31:0] rd_t0, rd_t1, rd_d, pr_rd_q;
    logic        irq_t0, irq_t1;
    logic        unused_addr_hi;

    // Only byte-address bits 15:0 take part in decode; each window spans 16 bytes.
    assign sel_t0         = (pr_addr[13:2] == T0_BASE[15:4]);
    assign sel_t1         = (pr_addr[13:2] == T1_BASE[15:4]);
    assign word_off       = pr_addr[1:0];
    assign unused_addr_hi = ^pr_addr[29:14];

    io_timer u_timer0 (
        .clk   (clk),
        .reset (reset),
        .we    (io_write & sel_t0),
        .off   (word_off),
        .wd    (pr_wd),
        .be    (pr_be),
        .rd    (rd_t0),
        .irq   (irq_t0)
    );

    io_timer u_timer1 (
        .clk   (clk),
        .reset (reset),
        .we    (io_write & sel_t1),
        .off   (word_off),
        .wd    (pr_wd),
        .be    (pr_be),
        .rd    (rd_t1),
        .irq   (irq_t1)
    );

    always_comb begin
        rd_d = 32'd0;
        if (sel_t0) begin
            rd_d = rd_t0;
        end else if (sel_t1) begin
            rd_d = rd_t1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pr_rd_q <= 32'd0;
        end else begin
            pr_rd_q <= rd_d;
        end
    end

    assign pr_rd = pr_rd_q;

    always_comb begin
        hw_int    = '0;
        hw_int[0] = irq_t0;
        hw_int[1] = irq_t1;
    end

endmodule

// File: tb/tb_io_bridge_timer.sv
// Directed bench for io_bridge_timer: register access, timer timing, interrupts, corner cases.
module tb_io_bridge_timer;

    localparam logic [15:0] T0 = 16'h7F00;
    localparam logic [15:0] T1 = 16'h7F10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        io_write = 1'b0;
    logic [29:0] pr_addr = '0;
    logic [31:0] pr_wd = '0;
    logic [3:0]  pr_be = '0;
    logic [31:0] pr_rd;
    logic [5:0]  hw_int;

    int n_tests = 0;
    int n_fail  = 0;

    io_bridge_timer dut (
        .clk      (clk),
        .reset    (reset),
        .io_write (io_write),
        .pr_addr  (pr_addr),
        .pr_wd    (pr_wd),
        .pr_be    (pr_be),
        .pr_rd    (pr_rd),
        .hw_int   (hw_int)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic [15:0] a);
        pr_addr = {16'h0, a[15:2]};
    endtask

    // The write lands on the next rising edge; returns 1 ns after it.
    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] b);
        set_addr(a);
        pr_wd    = d;
        pr_be    = b;
        io_write = 1'b1;
        cyc();
        io_write = 1'b0;
        pr_be    = 4'h0;
    endtask

    task automatic test_reset();
        logic [15:0] addrs [6] = '{T0, T0 + 16'h4, T0 + 16'h8, T1, T1 + 16'h4, T1 + 16'h8};
        #12;
        n_tests++;
        if (pr_rd !== 32'h0 || hw_int !== 6'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got pr_rd=%h hw_int=%b, expected 0/0", pr_rd, hw_int);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_addr(addrs[i]);
            cyc();
            n_tests++;
            if (pr_rd !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_reg%0d: got %h, expected %h", i, pr_rd, 32'h0);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        wr(T0 + 16'h4, 32'd5, 4'hF);
        wr(T0, 32'h9, 4'hF);
        set_addr(T0 + 16'h8);
        // LOAD after edge 1, COUNT=5 after edge 2, 4 after edge 3, visible on pr_rd after edge 4.
        repeat (4) cyc();
        n_tests++;
        if (pr_rd !== 32'd4) begin
            n_fail++;
            $display("FAIL midcount_before_reset: got %h, expected %h", pr_rd, 32'd4);
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (pr_rd !== 32'h0 || hw_int !== 6'h0) begin
            n_fail++;
            $display("FAIL midcount_async_reset: got pr_rd=%h hw_int=%b, expected 0/0", pr_rd, hw_int);
        end
        #2 reset = 1'b0;
        repeat (3) cyc();
        n_tests++;
        if (pr_rd !== 32'h0) begin
            n_fail++;
            $display("FAIL midcount_count_after: got %h, expected %h", pr_rd, 32'h0);
        end
        set_addr(T0 + 16'h4);
        cyc();
        n_tests++;
        if (pr_rd !== 32'h0) begin
            n_fail++;
            $display("FAIL midcount_preset_after: got %h, expected %h", pr_rd, 32'h0);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] exp_cnt [8] = '{32'd0, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0};
        logic [5:0]  exp_int;
        wr(T0 + 16'h4, 32'd3, 4'hF);
        wr(T0, 32'h9, 4'hF);
        set_addr(T0 + 16'h8);
        // IDLE, LOAD, CNT x4 (3..0), INT; the flag register is set on the edge leaving INT (edge 7).
        for (int k = 1; k <= 8; k++) begin
            cyc();
            exp_int = (k >= 7) ? 6'b000001 : 6'b000000;
            n_tests++;
            if (pr_rd !== exp_cnt[k-1] || hw_int !== exp_int) begin
                n_fail++;
                $display("FAIL oneshot_k%0d: got count=%h hw_int=%b, expected %h/%b",
                         k, pr_rd, hw_int, exp_cnt[k-1], exp_int);
            end
        end
        repeat (3) cyc();
        n_tests++;
        if (hw_int !== 6'b000001) begin
            n_fail++;
            $display("FAIL oneshot_sticky: got %b, expected %b", hw_int, 6'b000001);
        end
        set_addr(T0);
        cyc();
        n_tests++;
        if (pr_rd !== 32'h8) begin
            n_fail++;
            $display("FAIL oneshot_ctrl: got %h, expected %h", pr_rd, 32'h8);
        end
        wr(T0, 32'h0, 4'hF);
        n_tests++;
        if (hw_int !== 6'b000000) begin
            n_fail++;
            $display("FAIL oneshot_clear: got %b, expected %b", hw_int, 6'b000000);
        end
    endtask

    task automatic test_reload();
        logic [5:0] exp_int;
        wr(T1 + 16'h4, 32'd2, 4'hF);
        wr(T1, 32'hB, 4'hF);
        // Period = IDLE + LOAD + CNT x3 + INT = 6 cycles; first flag after edge 6.
        for (int k = 1; k <= 19; k++) begin
            cyc();
            exp_int = (k >= 6 && ((k - 6) % 6) == 0) ? 6'b000010 : 6'b000000;
            n_tests++;
            if (hw_int !== exp_int) begin
                n_fail++;
                $display("FAIL reload_k%0d: got %b, expected %b", k, hw_int, exp_int);
            end
        end
        set_addr(T1);
        cyc();
        n_tests++;
        if (pr_rd !== 32'hB) begin
            n_fail++;
            $display("FAIL reload_ctrl: got %h, expected %h", pr_rd, 32'hB);
        end
        wr(T1, 32'h0, 4'hF);
    endtask

    task automatic test_mask_be();
        logic [31:0] exp_cnt [8] = '{32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        wr(T0 + 16'h4, 32'd1, 4'hF);
        wr(T0, 32'h1, 4'hF);
        set_addr(T0 + 16'h8);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            n_tests++;
            if (pr_rd !== exp_cnt[k-1] || hw_int !== 6'h0) begin
                n_fail++;
                $display("FAIL mask_k%0d: got count=%h hw_int=%b, expected %h/%b",
                         k, pr_rd, hw_int, exp_cnt[k-1], 6'h0);
            end
        end
        wr(T0 + 16'h4, 32'h0, 4'hF);
        wr(T0 + 16'h4, 32'hAABBCCDD, 4'b0010);
        set_addr(T0 + 16'h4);
        cyc();
        n_tests++;
        if (pr_rd !== 32'h0000CC00) begin
            n_fail++;
            $display("FAIL byte_enable: got %h, expected %h", pr_rd, 32'h0000CC00);
        end
    endtask

    task automatic test_corners();
        wr(T0 + 16'h8, 32'h1234, 4'hF);
        set_addr(T0 + 16'h8);
        cyc();
        n_tests++;
        if (pr_rd !== 32'h0) begin
            n_fail++;
            $display("FAIL count_readonly: got %h, expected %h", pr_rd, 32'h0);
        end
        set_addr(T0 + 16'hC);
        cyc();
        n_tests++;
        if (pr_rd !== 32'h0) begin
            n_fail++;
            $display("FAIL offset3_read: got %h, expected %h", pr_rd, 32'h0);
        end
        wr(16'h7F40, 32'hFFFFFFFF, 4'hF);
        set_addr(T1 + 16'h4);
        cyc();
        n_tests++;
        if (pr_rd !== 32'd2) begin
            n_fail++;
            $display("FAIL unmapped_write_ignored: got %h, expected %h", pr_rd, 32'd2);
        end
        set_addr(16'h7F40);
        cyc();
        n_tests++;
        if (pr_rd !== 32'h0) begin
            n_fail++;
            $display("FAIL unmapped_read: got %h, expected %h", pr_rd, 32'h0);
        end
        wr(T1, 32'hFFFFFFF8, 4'hF);
        set_addr(T1);
        cyc();
        n_tests++;
        if (pr_rd !== 32'h8) begin
            n_fail++;
            $display("FAIL ctrl_upper_bits: got %h, expected %h", pr_rd, 32'h8);
        end
        wr(T1, 32'h0, 4'hF);
        wr(T0 + 16'h4, 32'h55, 4'hF);
        n_tests++;
        if (pr_rd !== 32'h0000CC00) begin
            n_fail++;
            $display("FAIL read_first_old: got %h, expected %h", pr_rd, 32'h0000CC00);
        end
        cyc();
        n_tests++;
        if (pr_rd !== 32'h55) begin
            n_fail++;
            $display("FAIL read_first_new: got %h, expected %h", pr_rd, 32'h55);
        end
    endtask

    task automatic test_write_during_int();
        logic [5:0] exp_int;
        wr(T0 + 16'h4, 32'h0, 4'hF);
        wr(T0, 32'h9, 4'hF);
        // LOAD after edge 1, CNT after 2, INT after 3; rewrite lands on edge 4.
        repeat (3) cyc();
        n_tests++;
        if (hw_int !== 6'h0) begin
            n_fail++;
            $display("FAIL wint_before: got %b, expected %b", hw_int, 6'h0);
        end
        wr(T0, 32'h9, 4'hF);
        n_tests++;
        if (hw_int !== 6'h0) begin
            n_fail++;
            $display("FAIL wint_write_wins: got %b, expected %b", hw_int, 6'h0);
        end
        // Restart: LOAD at edge 5, CNT 6, INT 7, flag after edge 8.
        for (int k = 5; k <= 8; k++) begin
            cyc();
            exp_int = (k == 8) ? 6'b000001 : 6'b000000;
            n_tests++;
            if (hw_int !== exp_int) begin
                n_fail++;
                $display("FAIL wint_restart_k%0d: got %b, expected %b", k, hw_int, exp_int);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_count();
        test_oneshot();
        test_reload();
        test_mask_be();
        test_corners();
        test_write_during_int();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
